// File: rtl/regfile_dumper.sv
// regfile_dumper: walks the integer register file in pairs, either clearing
// x1..x31 to CLEAR_VALUE or streaming all 32 registers out over a
// valid/ready dump port. Every output is decoded from registered state only.
module regfile_dumper #(
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        clear_req,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        enable,
  output logic [4:0]  rd,
  output logic [31:0] data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [4:0]  dump_idx,
  output logic [31:0] dump_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_SEND_A,
    S_SEND_B,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic [4:0]  wcnt_q, wcnt_d;
  logic [31:0] buf_a_q, buf_a_d;
  logic [31:0] buf_b_q, buf_b_d;

  // Read addresses always point at the current pair.
  assign rs1 = {k_q, 1'b0};
  assign rs2 = {k_q, 1'b1};

  // State, counters and pair buffers; asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      wcnt_q  <= '0;
      buf_a_q <= '0;
      buf_b_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      wcnt_q  <= wcnt_d;
      buf_a_q <= buf_a_d;
      buf_b_q <= buf_b_d;
    end
  end

  // Next-state logic and output decode from registered state.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    wcnt_d     = wcnt_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    enable     = 1'b0;
    rd         = '0;
    data       = '0;
    dump_valid = 1'b0;
    dump_idx   = '0;
    dump_data  = '0;
    busy       = 1'b1;
    done       = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (clear_req) begin
            state_d = S_CLEAR;
            wcnt_d  = 5'd1;
          end else begin
            state_d = S_FETCH;
            k_d     = '0;
          end
        end
      end
      S_CLEAR: begin
        enable = 1'b1;
        rd     = wcnt_q;
        data   = CLEAR_VALUE;
        if (wcnt_q == 5'd31) begin
          state_d = S_DONE;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 5'd1;
        end
      end
      S_FETCH: begin
        buf_a_d = op_a;
        buf_b_d = op_b;
        state_d = S_SEND_A;
      end
      S_SEND_A: begin
        dump_valid = 1'b1;
        dump_idx   = {k_q, 1'b0};
        dump_data  = buf_a_q;
        if (dump_ready) state_d = S_SEND_B;
      end
      S_SEND_B: begin
        dump_valid = 1'b1;
        dump_idx   = {k_q, 1'b1};
        dump_data  = buf_b_q;
        if (dump_ready) begin
          // k wraps to 0 after the last pair, so rs1/rs2 return to 0/1.
          k_d     = k_q + 4'd1;
          state_d = (k_q == 4'd15) ? S_DONE : S_FETCH;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: a register-file array drives op_a/op_b, a
// sequence-position model predicts every output each cycle, and directed
// scenarios pin latencies, stalls, ignored starts and mid-run reset.
module tb_regfile_dumper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        clear_req = 1'b0;
  logic        dump_ready = 1'b0;
  logic [4:0]  rs1, rs2, rd, dump_idx;
  logic [31:0] op_a, op_b, data, dump_data;
  logic        enable, dump_valid, busy, done;

  regfile_dumper #(.CLEAR_VALUE(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .start(start), .clear_req(clear_req),
    .rs1(rs1), .rs2(rs2), .op_a(op_a), .op_b(op_b),
    .enable(enable), .rd(rd), .data(data),
    .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register file (environment) ----------------
  logic [31:0] regs [32];
  logic        bd_we = 1'b0;
  logic [4:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;

  function automatic logic [31:0] rf_rd(input logic [4:0] a);
    return (a == 5'd0) ? 32'h0 : regs[a];
  endfunction

  assign op_a = rf_rd(rs1);
  assign op_b = rf_rd(rs2);

  always @(posedge clk) begin
    if (enable && rd != 5'd0) regs[rd] <= data;
    if (bd_we && bd_addr != 5'd0) regs[bd_addr] <= bd_data;
  end

  task automatic bd_write(input logic [4:0] a, input logic [31:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 clear, 2 dump, 3 done. pos: clear -> register being
  // written; dump -> step index 0..47, three steps (fetch, word A, word B) per pair.
  int          m_mode = 0;
  int          m_pos  = 0;
  logic [31:0] snap_a = '0, snap_b = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_pos = 0; snap_a = '0; snap_b = '0;
    end else begin
      case (m_mode)
        0: if (start) begin
             m_mode = clear_req ? 1 : 2;
             m_pos  = clear_req ? 1 : 0;
           end
        1: if (m_pos == 31) m_mode = 3; else m_pos++;
        2: if (m_pos % 3 == 0) begin
             snap_a = rf_rd(5'((m_pos / 3) * 2));
             snap_b = rf_rd(5'((m_pos / 3) * 2 + 1));
             m_pos++;
           end else if (dump_ready) begin
             if (m_pos == 47) m_mode = 3; else m_pos++;
           end
        default: m_mode = 0;
      endcase
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    int kk, sub;
    logic ev;
    kk  = (m_mode == 2) ? m_pos / 3 : 0;
    sub = m_pos % 3;
    ev  = (m_mode == 2) && (sub != 0);
    chk("rs1", 32'(rs1), 32'(2 * kk));
    chk("rs2", 32'(rs2), 32'(2 * kk + 1));
    chk("enable", 32'(enable), 32'(m_mode == 1));
    chk("rd", 32'(rd), (m_mode == 1) ? 32'(m_pos) : 32'h0);
    chk("data", data, 32'h0);
    chk("dump_valid", 32'(dump_valid), 32'(ev));
    chk("dump_idx", 32'(dump_idx), ev ? 32'(2 * kk + (sub == 2 ? 1 : 0)) : 32'h0);
    chk("dump_data", dump_data, !ev ? 32'h0 : (sub == 1 ? snap_a : snap_b));
    chk("busy", 32'(busy), 32'(m_mode != 0));
    chk("done", 32'(done), 32'(m_mode == 3));
  end

  int done_cnt = 0;
  int hs_cnt   = 0;
  always @(negedge clk) if (done) done_cnt++;
  always @(posedge clk) if (rst && dump_valid && dump_ready) hs_cnt++;

  // ---------------- helpers ----------------
  task automatic pulse_start(input logic clr);
    clear_req = clr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin @(negedge clk); n++; end
    if (busy) chk("wait_idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic wait_valid(input logic [4:0] idx, input int budget);
    int n = 0;
    forever begin
      @(negedge clk); n++;
      if (dump_valid && dump_idx == idx) break;
      if (n >= budget) begin
        chk("wait_valid_timeout", 32'(dump_idx), 32'(idx));
        break;
      end
    end
  endtask

  task automatic preload_random();
    for (int unsigned i = 1; i < 32; i++) bd_write(5'(i), $urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first_v, done_at, d0, h0;
    logic [31:0] old4, v6;
    logic [4:0]  wq_idx[$];
    logic [31:0] wq_dat[$];

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_rs2", 32'(rs2), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    #1 rst = 1'b1;
    dump_ready = 1'b1;

    // Clear sequence, with an ignored start pulse mid-way
    preload_random();
    d0 = done_cnt;
    pulse_start(1'b1);
    for (int unsigned i = 1; i <= 31; i++) begin
      @(negedge clk);
      chk("clr_enable", 32'(enable), 32'h1);
      chk("clr_rd", 32'(rd), 32'(i));
      if (i == 10) begin #1 clear_req = 1'b0; pulse_start(1'b0); end
    end
    @(negedge clk);
    chk("clr_done", 32'(done), 32'h1);
    wait_idle(10);
    chk("clr_done_count", 32'(done_cnt - d0), 32'h1);
    for (int unsigned i = 1; i < 32; i++) chk("clr_readback", regs[i], 32'h0);

    // Full dump with ready held, start pulsed during SEND_B of x13
    for (int unsigned i = 1; i < 32; i++) bd_write(5'(i), 32'h1000_0000 + 32'(i));
    d0 = done_cnt; cnt = 0; first_v = 0; done_at = 0;
    @(negedge clk); #1;
    pulse_start(1'b0);
    while (cnt < 100) begin
      @(negedge clk); cnt++;
      if (dump_valid && first_v == 0) first_v = cnt;
      if (dump_valid && dump_ready) begin wq_idx.push_back(dump_idx); wq_dat.push_back(dump_data); end
      if (done) begin done_at = cnt; break; end
      #1;
      clear_req = 1'b1;
      start = dump_valid && dump_idx == 5'd13;
    end
    #1 start = 1'b0;
    chk("dump_first_valid", 32'(first_v), 32'd2);
    chk("dump_done_at", 32'(done_at), 32'd49);
    chk("dump_words", 32'(wq_idx.size()), 32'd32);
    for (int i = 0; i < wq_idx.size() && i < 32; i++) begin
      chk("dump_idx_seq", 32'(wq_idx[i]), 32'(i));
      chk("dump_val_seq", wq_dat[i], (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i));
    end
    wait_idle(10);
    chk("dump_done_count", 32'(done_cnt - d0), 32'h1);

    // Stall in SEND_A of k=2 while x4 is overwritten, then 5-cycle stall at x6
    preload_random();
    h0 = hs_cnt;
    dump_ready = 1'b1;
    pulse_start(1'b0);
    wait_valid(5'd4, 40);
    #1 dump_ready = 1'b0;
    old4 = regs[4];
    bd_write(5'd4, ~old4);
    @(negedge clk);
    chk("x4_idx", 32'(dump_idx), 32'd4);
    chk("x4_prewrite", dump_data, old4);
    #1 dump_ready = 1'b1;
    wait_valid(5'd6, 40);
    #1 dump_ready = 1'b0;
    v6 = regs[6];
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", 32'(dump_valid), 32'h1);
      chk("stall_idx", 32'(dump_idx), 32'd6);
      chk("stall_data", dump_data, v6);
    end
    #1 dump_ready = 1'b1;
    wait_idle(200);
    chk("stall_word_count", 32'(hs_cnt - h0), 32'd32);

    // Asynchronous reset while presenting x9
    pulse_start(1'b0);
    wait_valid(5'd9, 60);
    h0 = hs_cnt;
    #1 rst = 1'b0;
    #1;
    chk("arst_enable", 32'(enable), 32'h0);
    chk("arst_valid", 32'(dump_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("arst_stays_idle", 32'(busy), 32'h0);
    chk("arst_no_words", 32'(hs_cnt - h0), 32'h0);

    // Randomized sequences: random ready, random spurious starts
    for (int unsigned it = 0; it < 8; it++) begin
      bd_write(5'($urandom_range(1, 31)), $urandom);
      d0 = done_cnt;
      pulse_start(1'($urandom_range(0, 1)));
      cnt = 0;
      while (cnt < 400) begin
        @(negedge clk); cnt++;
        if (done) break;
        #1;
        dump_ready = 1'($urandom_range(0, 1));
        clear_req  = 1'($urandom_range(0, 1));
        start      = ($urandom_range(0, 7) == 0);
      end
      #1 start = 1'b0;
      if (!done) chk("rand_timeout", 32'(done), 32'h1);
      wait_idle(10);
      chk("rand_done_count", 32'(done_cnt - d0), 32'h1);
      dump_ready = 1'b1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
